// File: rtl/pit_intc.sv
// pit_intc: periodic interval timer plus edge-triggered interrupt collector
// sitting in a 16-byte MMIO window at BASE.
//
// Registers (index = addr[3:2]):
//   0 LOAD    RW   reload value; a write also restarts COUNT
//   1 COUNT   RO   down-counter, advances on clk_en edges
//   2 PENDING R/W1C bit 0 = timer tick, bit i+1 = rising edge of irq_src[i]
//   3 MASK    RW   bits [15:0], upper bits read 0
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   clk_en            CPU advance pulse; gates the timer and writes
//   irq_src[14:0]     external level sources, synchronous to clk
//   mem_we/addr/data  CPU byte-lane write port
//   mem_re/read_addr  CPU read port
//   rdata             registered read data (1-cycle latency)
//   interrupts        registered PENDING & MASK
module pit_intc #(
   parameter logic [17:0] BASE  = 18'h3FFF0,
   parameter int          CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic [14:0] irq_src,
   input  logic [3:0]  mem_we,
   input  logic [17:0] mem_write_addr,
   input  logic [31:0] mem_write_data,
   input  logic        mem_re,
   input  logic [17:0] mem_read_addr,
   output logic [31:0] rdata,
   output logic [15:0] interrupts
);

   localparam logic [1:0] IDX_LOAD  = 2'd0;
   localparam logic [1:0] IDX_COUNT = 2'd1;
   localparam logic [1:0] IDX_PEND  = 2'd2;

   logic [CNT_W-1:0] load_q, load_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [15:0]      pend_q, pend_d;
   logic [15:0]      mask_q, mask_d;
   logic [14:0]      irq_q;
   logic [15:0]      intr_q;
   logic [31:0]      rdata_q, rdata_d;

   logic        w_hit, r_hit, wr_en;
   logic        wr_load, wr_pend, wr_mask;
   logic [1:0]  w_idx, r_idx;
   logic [31:0] be_mask;
   logic [31:0] load_ext, count_ext, load_wdata;
   logic [15:0] pend_set, pend_clr;
   logic        tick;

   assign w_hit = (mem_write_addr[17:4] == BASE[17:4]);
   assign r_hit = (mem_read_addr[17:4] == BASE[17:4]);
   assign w_idx = mem_write_addr[3:2];
   assign r_idx = mem_read_addr[3:2];

   assign wr_en   = clk_en & w_hit & (|mem_we);
   assign wr_load = wr_en & (w_idx == IDX_LOAD);
   assign wr_pend = wr_en & (w_idx == IDX_PEND);
   assign wr_mask = wr_en & (w_idx == 2'd3);

   assign be_mask = {{8{mem_we[3]}}, {8{mem_we[2]}},
                     {8{mem_we[1]}}, {8{mem_we[0]}}};

   assign load_ext   = 32'(load_q);
   assign count_ext  = 32'(count_q);
   assign load_wdata = (load_ext & ~be_mask)
                     | (mem_write_data & be_mask);

   always_comb begin
      load_d  = load_q;
      count_d = count_q;
      tick    = 1'b0;
      if (wr_load) begin
         load_d  = CNT_W'(load_wdata);
         count_d = CNT_W'(load_wdata);
      end else if (clk_en) begin
         if (load_q == '0) begin
            count_d = '0;
         end else if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
         end else begin
            // COUNT of 0 or 1 both wrap, so a stale 0 cannot stall
            count_d = load_q;
            tick    = 1'b1;
         end
      end
   end

   always_comb begin
      mask_d = mask_q;
      if (wr_mask) begin
         mask_d = (mask_q & ~be_mask[15:0])
                | (mem_write_data[15:0] & be_mask[15:0]);
      end
   end

   // Set is OR'd in after the clear, so a same-edge set wins.
   assign pend_clr = wr_pend ? (mem_write_data[15:0] & be_mask[15:0])
                             : 16'h0;
   assign pend_set = {irq_src & ~irq_q, tick};
   assign pend_d   = (pend_q & ~pend_clr) | pend_set;

   always_comb begin
      rdata_d = rdata_q;
      if (mem_re) begin
         rdata_d = 32'h0;
         if (r_hit) begin
            case (r_idx)
               IDX_LOAD:  rdata_d = load_ext;
               IDX_COUNT: rdata_d = count_ext;
               IDX_PEND:  rdata_d = {16'h0, pend_q};
               default:   rdata_d = {16'h0, mask_q};
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_q  <= '0;
         count_q <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
         irq_q   <= '0;
         intr_q  <= '0;
         rdata_q <= '0;
      end else begin
         load_q  <= load_d;
         count_q <= count_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         irq_q   <= irq_src;
         intr_q  <= pend_q & mask_q;
         rdata_q <= rdata_d;
      end
   end

   assign rdata      = rdata_q;
   assign interrupts = intr_q;

endmodule

// File: tb/tb_pit_intc.sv
// Directed bench for pit_intc: timer, edge capture, W1C, byte lanes,
// same-edge read/write, reset and window decode.
module tb_pit_intc;

   localparam logic [17:0] BASE  = 18'h3FFF0;
   localparam logic [17:0] A_LD  = BASE + 18'd0;
   localparam logic [17:0] A_CNT = BASE + 18'd4;
   localparam logic [17:0] A_PND = BASE + 18'd8;
   localparam logic [17:0] A_MSK = BASE + 18'd12;
   localparam logic [17:0] A_MISS = BASE + 18'd16;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic [14:0] irq_src;
   logic [3:0]  mem_we;
   logic [17:0] mem_write_addr;
   logic [31:0] mem_write_data;
   logic        mem_re;
   logic [17:0] mem_read_addr;
   logic [31:0] rdata;
   logic [15:0] interrupts;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   pit_intc #(.BASE(BASE), .CNT_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .clk_en(clk_en),
      .irq_src(irq_src),
      .mem_we(mem_we),
      .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data),
      .mem_re(mem_re),
      .mem_read_addr(mem_read_addr),
      .rdata(rdata),
      .interrupts(interrupts)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [17:0] a, input logic [31:0] d,
                     input logic [3:0] we);
      mem_write_addr = a;
      mem_write_data = d;
      mem_we         = we;
      @(negedge clk);
      mem_we         = 4'h0;
   endtask

   task automatic rd(input string tag, input logic [17:0] a,
                     input logic [31:0] exp);
      logic [31:0] e;
      mem_read_addr = a;
      mem_re        = 1'b1;
      sb_q.push_back(exp);
      @(negedge clk);
      mem_re = 1'b0;
      total++;
      assert (sb_q.size() != 0) else begin
         bad++;
         $error("FAIL %s: observed=empty expected=entry", tag);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check(tag, rdata, e);
      end
   endtask

   initial begin
      rst            = 1'b1;
      clk_en         = 1'b1;
      irq_src        = '0;
      mem_we         = '0;
      mem_write_addr = '0;
      mem_write_data = '0;
      mem_re         = 1'b0;
      mem_read_addr  = '0;
      cyc(2);
      check("rst_intr", 32'(interrupts), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      rst = 1'b0;
      rd("rst_load", A_LD, 32'h0);
      rd("rst_mask", A_MSK, 32'h0);

      // periodic timer, LOAD=3
      wr(A_MSK, 32'h1, 4'hF);
      wr(A_LD, 32'd3, 4'hF);
      cyc(2);
      check("tmr_e2", 32'(interrupts), 32'h0);
      cyc(1);
      check("tmr_e3", 32'(interrupts), 32'h0);
      rd("tmr_pend", A_PND, 32'h1);
      check("tmr_intr", 32'(interrupts), 32'h1);
      wr(A_PND, 32'h1, 4'hF);
      check("tmr_w1c_lag", 32'(interrupts), 32'h1);
      cyc(1);
      check("tmr_clr", 32'(interrupts), 32'h0);
      cyc(1);
      check("tmr_rep", 32'(interrupts), 32'h1);
      wr(A_LD, 32'h0, 4'hF);
      wr(A_PND, 32'hFFFF, 4'hF);
      wr(A_MSK, 32'h0, 4'hF);

      // clk_en 1-in-4, LOAD=2
      wr(A_LD, 32'd2, 4'hF);
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 4; k++) begin
            clk_en = (k == 3);
            if (k == 0) rd("gate_cnt", A_CNT, 32'(2 - p));
            else if (k == 1) rd("gate_pnd", A_PND, 32'h0);
            else cyc(1);
         end
      end
      clk_en = 1'b0;
      rd("gate_pset", A_PND, 32'h1);
      rd("gate_reld", A_CNT, 32'd2);
      clk_en = 1'b1;
      wr(A_LD, 32'h0, 4'hF);
      wr(A_PND, 32'hFFFF, 4'hF);

      // edge capture on irq_src[4]
      wr(A_MSK, 32'hFFFF_FFFF, 4'hF);
      rd("mask_hi0", A_MSK, 32'h0000_FFFF);
      irq_src[4] = 1'b1;
      cyc(1);
      irq_src[4] = 1'b0;
      cyc(1);
      check("edge_intr", 32'(interrupts), 32'h20);
      rd("edge_pnd", A_PND, 32'h20);
      wr(A_PND, 32'h20, 4'hF);
      check("w1c_lag", 32'(interrupts), 32'h20);
      cyc(1);
      check("w1c_clr", 32'(interrupts), 32'h0);
      irq_src[4] = 1'b1;
      cyc(1);
      wr(A_PND, 32'h20, 4'hF);
      cyc(2);
      check("lvl_intr", 32'(interrupts), 32'h0);
      rd("lvl_pnd", A_PND, 32'h0);
      irq_src[4] = 1'b0;

      // same-edge set beats W1C
      irq_src[2] = 1'b1;
      cyc(1);
      irq_src[2] = 1'b0;
      cyc(1);
      rd("pri_pre", A_PND, 32'h8);
      irq_src[2] = 1'b1;
      wr(A_PND, 32'h8, 4'hF);
      rd("pri_set", A_PND, 32'h8);
      wr(A_PND, 32'hFFFF, 4'hF);
      rd("pri_clr", A_PND, 32'h0);
      irq_src[2] = 1'b0;
      wr(A_MSK, 32'h0, 4'hF);

      // byte-lane write to LOAD
      wr(A_LD, 32'h1122_3344, 4'hF);
      wr(A_LD, 32'h0000_AB00, 4'b0010);
      rd("byte_cnt", A_CNT, 32'h1122_AB44);
      rd("byte_ld", A_LD, 32'h1122_AB44);

      // read and write LOAD on the same edge
      mem_write_addr = A_LD;
      mem_write_data = 32'd1;
      mem_we         = 4'hF;
      rd("rw_same", A_LD, 32'h1122_AB44);
      mem_we = 4'h0;

      // build COUNT=5, PENDING=3, MASK=3, then reset
      wr(A_MSK, 32'h3, 4'hF);
      wr(A_LD, 32'd5, 4'hF);
      clk_en = 1'b0;
      irq_src[0] = 1'b1;
      cyc(1);
      irq_src[0] = 1'b0;
      cyc(1);
      check("pre_rst_intr", 32'(interrupts), 32'h3);
      rd("pre_rst_cnt", A_CNT, 32'd5);
      rd("pre_rst_pnd", A_PND, 32'h3);
      irq_src[6] = 1'b1;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("post_rst_intr", 32'(interrupts), 32'h0);
      check("post_rst_rdata", rdata, 32'h0);
      rd("post_rst_cnt", A_CNT, 32'h0);
      rd("held_src", A_PND, 32'h80);
      irq_src[6] = 1'b0;
      check("post_rst_mask", 32'(interrupts), 32'h0);

      // window miss
      clk_en = 1'b1;
      wr(A_MISS, 32'hFFFF_FFFF, 4'hF);
      rd("miss_pre", A_PND, 32'h80);
      rd("miss_rd", A_MISS, 32'h0);
      rd("miss_ld", A_LD, 32'h0);
      rd("miss_msk", A_MSK, 32'h0);
      rd("miss_pnd", A_PND, 32'h80);

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pit_intc.md
PIT_INTC -- requirements
Module: pit_intc

Interface
REQ-001 SHALL have parameter BASE, default 18'h3FFF0, giving the MMIO window base; bits [3:0] are zero and the window is 16 bytes.
REQ-002 SHALL have parameter CNT_W, default 32, giving the timer width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL have port clk_en, input, 1 bit: the CPU advance pulse.
REQ-006 SHALL have port irq_src, input, 15 bits: external level sources, synchronous to clk.
REQ-007 SHALL have port mem_we, input, 4 bits: byte-lane write enables from the CPU.
REQ-008 SHALL have port mem_write_addr, input, 18 bits: the CPU write byte address.
REQ-009 SHALL have port mem_write_data, input, 32 bits: the CPU write data.
REQ-010 SHALL have port mem_re, input, 1 bit: CPU read strobe.
REQ-011 SHALL have port mem_read_addr, input, 18 bits: CPU read byte address.
REQ-012 SHALL have port rdata, output, 32 bits: registered read data.
REQ-013 SHALL have port interrupts, output, 16 bits: registered masked pending vector, feeding the CPU interrupts input.

Function
REQ-014 SHALL decode an access as a hit when addr[17:4] == BASE[17:4]; the register index is addr[3:2] and addr[1:0] are ignored.
REQ-015 SHALL implement index 0 as LOAD (RW), index 1 as COUNT (RO), index 2 as PENDING (read; write-1-to-clear), and index 3 as MASK (RW, bits [15:0]; bits [31:16] read 0).
REQ-016 SHALL perform writes only on clk edges with clk_en=1, a hit, and mem_we!=0; each byte lane i is written only if mem_we[i]=1.
REQ-017 SHALL ignore writes to COUNT except that any hit write to LOAD also sets COUNT to the new LOAD value on the same edge.
REQ-018 SHALL, on each clk_en edge where LOAD!=0 and no LOAD write occurs: decrement COUNT if COUNT>1; if COUNT<=1, reload COUNT from LOAD and set PENDING[0].
REQ-019 SHALL, when LOAD==0, hold COUNT at 0 and never set PENDING[0].
REQ-020 SHALL register irq_src every clk edge, independent of clk_en.
REQ-021 SHALL set PENDING[i+1] on a rising edge of irq_src[i] (current=1, previous=0); levels held high SHALL NOT re-set a bit after it is cleared.
REQ-022 SHALL give a same-edge hardware set priority over a W1C clear of the same bit.
REQ-023 SHALL leave bits [31:16] of PENDING as 0 and ignore writes to them.
REQ-024 SHALL latch interrupts <= PENDING & MASK on every edge, using the pre-edge register values, so assertion follows the set by 1 cycle.
REQ-025 SHALL update rdata on clk edges where mem_re=1: register contents on a hit, 0 on a miss; otherwise rdata holds its value. Read latency is 1 cycle and reads have no side effects.
REQ-026 SHALL return the pre-edge register value when a read and a write to the same register occur on the same edge.
REQ-027 SHALL keep PENDING sticky across clk_en=0 cycles; only the timer and writes are gated by clk_en.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, clear LOAD, COUNT, PENDING, MASK, the irq_src history, rdata and interrupts to 0, overriding all other activity on that edge.
REQ-029 SHALL, when reset is applied mid-count or with bits pending, leave no interrupt asserted on the cycle after reset, and treat any source held high through reset as an edge on the first cycle after reset.

Verification
REQ-030 SHALL be verified by: clk_en=1 always; write MASK=0x1, LOAD=3 -> PENDING[0] sets on the 3rd clk_en edge after the write, and interrupts=16'h0001 one cycle later; the timer then repeats every 3 edges.
REQ-031 SHALL be verified by: clk_en pulsing 1-in-4; LOAD=2 -> PENDING[0] sets only after 2 clk_en pulses, and COUNT is unchanged on non-enable cycles.
REQ-032 SHALL be verified by: MASK=0xFFFF, pulse irq_src[4] high for 1 cycle -> PENDING=0x20 and interrupts=0x0020; a W1C write 0x20 to BASE+8 -> interrupts=0 two cycles later; holding irq_src[4] high does not re-set the bit.
REQ-033 SHALL be verified by: a W1C of bit 3 on the same edge as a rising edge of irq_src[2] -> PENDING[3] remains 1.
REQ-034 SHALL be verified by: a byte write mem_we=4'b0010, data 0x0000AB00 to BASE+0 with LOAD=0x11223344 -> LOAD=0x1122AB44 and COUNT=0x1122AB44; a read of BASE+4 returns it one cycle later.
REQ-035 SHALL be verified by: asserting rst with COUNT=5, PENDING=0x3 and MASK=0x3 -> the next cycle has interrupts=0, COUNT=0 and rdata=0; an access to BASE+16 (miss) writes nothing and reads 0.
